// File: rtl/dffasr_stim_pkg.sv
// Shared types and constants for the async set/reset flip-flop stimulus sequencer.
package dffasr_stim_pkg;

   typedef enum logic [1:0] {
      LOAD0 = 2'b00,
      LOAD1 = 2'b01,
      RESET = 2'b10,
      SET   = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      CLK_HI,
      CLK_LO,
      PULSE,
      RECOV,
      SAMPLE
   } state_e;

   // LOAD sequence: setup, clock high, hold, then the sample cycle.
   localparam int unsigned LOAD_SETUP_CYC = 1;
   localparam int unsigned LOAD_CLKHI_CYC = 1;
   localparam int unsigned LOAD_HOLD_CYC  = 1;
   localparam int unsigned LOAD_RSP_LAT   = LOAD_SETUP_CYC + LOAD_CLKHI_CYC + LOAD_HOLD_CYC + 1;

   function automatic int unsigned cnt_width(input int unsigned max_cyc);
      return (max_cyc > 1) ? $clog2(max_cyc) : 1;
   endfunction

   // Cycles from acceptance to rsp_valid for a given op.
   function automatic int unsigned op_latency(input op_e op, input int unsigned pw_cyc,
                                              input int unsigned rec_cyc);
      return op[1] ? (pw_cyc + rec_cyc + 1) : LOAD_RSP_LAT;
   endfunction

endpackage

// File: rtl/dffasr_stim_timer.sv
// Loadable down-counter timing the async pulse and recovery windows.
module dffasr_stim_timer
   import dffasr_stim_pkg::*;
#(
   parameter  int unsigned MAX_CYC = 2,
   localparam int unsigned CNT_W   = cnt_width(MAX_CYC)
) (
   input  logic             CLK,
   input  logic             RSTB,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   // Loading N-1 makes done rise in the Nth cycle after the load edge.
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/dffasr_stim_ctrl.sv
// Command-driven stimulus/check sequencer for one async set/reset flip-flop cell.
module dffasr_stim_ctrl
   import dffasr_stim_pkg::*;
#(
   parameter int unsigned PW_CYC  = 2,
   parameter int unsigned REC_CYC = 2,
   parameter int unsigned ERR_W   = 8
) (
   input  logic             CLK,
   input  logic             RSTB,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   output logic             rsp_valid,
   output logic             rsp_pass,
   output logic             rsp_q,
   output logic [ERR_W-1:0] err_cnt,
   output logic             dut_d,
   output logic             dut_clk,
   output logic             dut_rstb,
   output logic             dut_setb,
   input  logic             dut_q,
   input  logic             dut_qn
);

   if (PW_CYC < 1) begin : g_bad_pw
      $error("dffasr_stim_ctrl: PW_CYC must be >= 1");
   end
   if (REC_CYC < 1) begin : g_bad_rec
      $error("dffasr_stim_ctrl: REC_CYC must be >= 1");
   end

   localparam int unsigned TMR_MAX = (PW_CYC > REC_CYC) ? PW_CYC : REC_CYC;
   localparam int unsigned TMR_W   = cnt_width(TMR_MAX);

   state_e           state;
   op_e              op;
   logic             tmr_load;
   logic [TMR_W-1:0] tmr_val;
   logic             tmr_done;
   logic             exp_q;
   logic             chk_pass;
   logic             enter_sample;

   assign cmd_ready = (state == IDLE);

   // For every op the expected Q equals op bit 0 (LOAD1 and SET give 1).
   assign exp_q    = op[0];
   assign chk_pass = (dut_q === exp_q) && (dut_qn === ~exp_q);

   assign enter_sample = (state == CLK_LO) || ((state == RECOV) && tmr_done);

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = TMR_W'(PW_CYC - 1);
      if ((state == IDLE) && cmd_valid && cmd_op[1]) begin
         tmr_load = 1'b1;
      end else if ((state == PULSE) && tmr_done) begin
         tmr_load = 1'b1;
         tmr_val  = TMR_W'(REC_CYC - 1);
      end
   end

   dffasr_stim_timer #(
      .MAX_CYC (TMR_MAX)
   ) u_timer (
      .CLK      (CLK),
      .RSTB     (RSTB),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state     <= IDLE;
         op        <= LOAD0;
         rsp_valid <= 1'b0;
         rsp_pass  <= 1'b0;
         rsp_q     <= 1'b0;
         err_cnt   <= '0;
         dut_d     <= 1'b0;
         dut_clk   <= 1'b0;
         dut_rstb  <= 1'b1;
         dut_setb  <= 1'b1;
      end else begin
         rsp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  op <= op_e'(cmd_op);
                  if (!cmd_op[1]) begin
                     dut_d <= cmd_op[0];
                     state <= DRIVE;
                  end else begin
                     // Only one of the async pins is ever pulled low.
                     dut_rstb <= cmd_op[0];
                     dut_setb <= ~cmd_op[0];
                     state    <= PULSE;
                  end
               end
            end
            DRIVE: begin
               dut_clk <= 1'b1;
               state   <= CLK_HI;
            end
            CLK_HI: begin
               dut_clk <= 1'b0;
               state   <= CLK_LO;
            end
            CLK_LO: begin
               state <= SAMPLE;
            end
            PULSE: begin
               if (tmr_done) begin
                  dut_rstb <= 1'b1;
                  dut_setb <= 1'b1;
                  state    <= RECOV;
               end
            end
            RECOV: begin
               if (tmr_done) begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase

         if (enter_sample) begin
            rsp_valid <= 1'b1;
            rsp_q     <= dut_q;
            rsp_pass  <= chk_pass;
            if (!chk_pass && (err_cnt != '1)) begin
               err_cnt <= err_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dffasr_stim_ctrl.sv
// Scoreboard bench: behavioural DFFASR cell with fault modes driven by dffasr_stim_ctrl.
module tb_dffasr_stim_ctrl;

   localparam int unsigned PW  = 3;
   localparam int unsigned REC = 2;
   localparam int unsigned EW  = 2;

   logic          CLK = 1'b0;
   logic          RSTB = 1'b0;
   logic          cmd_valid = 1'b0;
   logic [1:0]    cmd_op = 2'b00;
   logic          cmd_ready;
   logic          rsp_valid, rsp_pass, rsp_q;
   logic [EW-1:0] err_cnt;
   logic          dut_d, dut_clk, dut_rstb, dut_setb;
   logic          dut_q, dut_qn;

   // 0: healthy cell, 1: QN tied to Q, 2: Q stuck at 0
   int            fault = 0;
   logic          cell_q;

   always #5 CLK = ~CLK;

   dffasr_stim_ctrl #(
      .PW_CYC  (PW),
      .REC_CYC (REC),
      .ERR_W   (EW)
   ) dut (
      .CLK       (CLK),
      .RSTB      (RSTB),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .rsp_valid (rsp_valid),
      .rsp_pass  (rsp_pass),
      .rsp_q     (rsp_q),
      .err_cnt   (err_cnt),
      .dut_d     (dut_d),
      .dut_clk   (dut_clk),
      .dut_rstb  (dut_rstb),
      .dut_setb  (dut_setb),
      .dut_q     (dut_q),
      .dut_qn    (dut_qn)
   );

   always @(posedge dut_clk or negedge dut_rstb or negedge dut_setb) begin
      if (!dut_rstb)      cell_q <= 1'b0;
      else if (!dut_setb) cell_q <= 1'b1;
      else                cell_q <= dut_d;
   end

   assign dut_q  = (fault == 2) ? 1'b0 : cell_q;
   assign dut_qn = (fault == 1) ? dut_q : ~dut_q;

   int n_chk = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic q;
      logic pass;
      int   cyc;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          err_model = 0;
   logic        d_model = 1'b0;
   int          rstb_run = 0;
   int          setb_run = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (!RSTB) begin
         sb.delete();
         err_model = 0;
         d_model   = 1'b0;
         rstb_run  = 0;
         setb_run  = 0;
      end else begin
         check_eq("d_hold", dut_d, d_model);
         check_eq("async_not_both_low", dut_rstb | dut_setb, 1);
         if (!dut_rstb || !dut_setb) check_eq("clk_low_in_pulse", dut_clk, 0);
         if (!dut_setb) setb_run++;
         else if (setb_run != 0) begin
            check_eq("setb_width", setb_run, PW);
            setb_run = 0;
         end
         if (!dut_rstb) rstb_run++;
         else if (rstb_run != 0) begin
            check_eq("rstb_width", rstb_run, PW);
            rstb_run = 0;
         end
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               check_eq("spurious_rsp", rsp_valid, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check_eq("rsp_q", rsp_q, e.q);
               check_eq("rsp_pass", rsp_pass, e.pass);
               check_eq("rsp_latency", cyc, e.cyc);
               if (!e.pass && err_model < 3) err_model++;
               check_eq("err_cnt", err_cnt, err_model);
            end
         end
         if (cmd_valid && cmd_ready) begin
            exp_t e;
            logic x;
            x = cmd_op[0];
            e.q    = (fault == 2) ? 1'b0 : x;
            e.pass = (fault == 0) ? 1'b1 : (fault == 1) ? 1'b0 : (x == 1'b0);
            e.cyc  = cyc + (cmd_op[1] ? (PW + REC + 1) : 4);
            sb.push_back(e);
            if (!cmd_op[1]) d_model = x;
         end
      end
   end

   task automatic send(input logic [1:0] op);
      int n;
      n = 0;
      @(posedge CLK); #1;
      while (!cmd_ready && n < 40) begin
         @(posedge CLK); #1;
         n++;
      end
      if (!cmd_ready) check_eq("ready_timeout", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      @(posedge CLK); #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom_range(0, 3));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || !cmd_ready) && n < 60) begin
         @(posedge CLK); #1;
         n++;
      end
      check_eq("drain", sb.size(), 0);
   endtask

   initial begin
      #12;
      check_eq("rst_cmd_ready", cmd_ready, 1);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_rsp_pass", rsp_pass, 0);
      check_eq("rst_rsp_q", rsp_q, 0);
      check_eq("rst_err_cnt", err_cnt, 0);
      check_eq("rst_dut_d", dut_d, 0);
      check_eq("rst_dut_clk", dut_clk, 0);
      check_eq("rst_dut_rstb", dut_rstb, 1);
      check_eq("rst_dut_setb", dut_setb, 1);
      @(posedge CLK); #1;
      RSTB = 1'b1;

      // Healthy cell: loads then async set/reset.
      send(2'b01);
      send(2'b00);
      drain();
      check_eq("err_after_loads", err_cnt, 0);
      send(2'b11);
      send(2'b10);
      send(2'b11);
      drain();
      check_eq("err_after_async", err_cnt, 0);

      // QN tied to Q.
      fault = 1;
      send(2'b01);
      drain();
      check_eq("err_after_fault", err_cnt, 1);

      // Q stuck at 0: LOAD0 still passes, LOAD1 saturates the counter.
      fault = 2;
      send(2'b00);
      for (int i = 0; i < 5; i++) send(2'b01);
      drain();
      check_eq("err_saturated", err_cnt, 3);
      fault = 0;

      // Reset in the second PULSE cycle of a RESET op.
      send(2'b10);
      @(posedge CLK); #3;
      RSTB = 1'b0;
      #1;
      check_eq("midrst_dut_rstb", dut_rstb, 1);
      check_eq("midrst_cmd_ready", cmd_ready, 1);
      check_eq("midrst_rsp_valid", rsp_valid, 0);
      check_eq("midrst_err_cnt", err_cnt, 0);
      repeat (2) @(posedge CLK);
      #1;
      RSTB = 1'b1;
      repeat (10) @(posedge CLK);
      #1;
      check_eq("midrst_idle_ready", cmd_ready, 1);

      // Backpressure: valid held high while the op changes every cycle.
      send(2'b01);
      drain();
      @(posedge CLK); #1;
      cmd_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         cmd_op = 2'($urandom_range(0, 3));
         @(posedge CLK); #1;
      end
      cmd_valid = 1'b0;
      drain();
      check_eq("bp_err_cnt", err_cnt, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/dffasr_stim_ctrl.md
# dffasr_stim_ctrl

Command-driven stimulus/check sequencer for async set/reset flip-flop cells (e.g. DFFASRX1) in the power-characterisation benches. It is the driving end of the cell's D/CLK/RSTB/SETB interface. It turns op commands into a cell clock pulse or async pulses that honour the cell's setup, hold, pulse-width and recovery requirements, samples Q/QN, and reports pass/fail per op. It sits between the bench command source and one cell under test.

## Interface
- PW_CYC, 2: async pulse width on dut_rstb/dut_setb, in CLK cycles; must be ≥1, elaboration error otherwise.
- REC_CYC, 2: cycles from async deassert to sample; must be ≥1, elaboration error otherwise.
- ERR_W, 8: width of the error counter.

Ports:
- CLK  in  1  block clock; all state updates on posedge.
- RSTB  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; equals (state==IDLE).
- cmd_op  in  2  00 LOAD0, 01 LOAD1, 10 RESET, 11 SET.
- rsp_valid  out  1  one-cycle result strobe.
- rsp_pass  out  1  result of the check; valid with rsp_valid.
- rsp_q  out  1  sampled dut_q; valid with rsp_valid.
- err_cnt  out  ERR_W  count of failed checks, saturating.
- dut_d, dut_clk, dut_rstb, dut_setb  out  1 each  registered cell drives.
- dut_q, dut_qn  in  1 each  cell outputs.

## Operation
- Reset values: state IDLE, cmd_ready 1, rsp_valid 0, rsp_pass 0, rsp_q 0, err_cnt 0, dut_d 0, dut_clk 0, dut_rstb 1, dut_setb 1.
- Accept: a command is accepted on a posedge with cmd_valid & cmd_ready. The op is latched; cmd_op is ignored at all other times.
- LOAD0/LOAD1 sequence:
  - DRIVE: dut_d = op[0] (setup cycle).
  - CLK_HI: dut_clk = 1.
  - CLK_LO: dut_clk = 0; dut_d is held (hold cycle).
  - SAMPLE: expected q = op[0].
- RESET sequence:
  - PULSE: dut_rstb = 0 for PW_CYC cycles.
  - RECOV: dut_rstb = 1 for REC_CYC cycles.
  - SAMPLE: expected q = 0.
- SET sequence: same as RESET, but on dut_setb; expected q = 1.
- SAMPLE state (one cycle):
  - rsp_valid = 1; rsp_q = dut_q.
  - rsp_pass = (dut_q === exp) && (dut_qn === ~exp). X or Z on either input counts as a fail.
  - On fail, err_cnt increments, saturating at 2^ERR_W−1.
  - Next state is IDLE.
- Invariants:
  - dut_rstb and dut_setb are never both 0.
  - dut_clk is never 1 during PULSE or RECOV.
  - dut_d changes only in DRIVE.
  - dut_d retains its last LOAD value across RESET/SET and IDLE.
- Reset mid-operation: immediate return to reset values; no rsp_valid is issued; err_cnt clears.

## Timing
- Command accepted at edge 0:
  - LOAD: DRIVE in cycle 1, CLK_HI in cycle 2, CLK_LO in cycle 3, SAMPLE (rsp_valid) in cycle 4, cmd_ready = 1 in cycle 5.
  - RESET/SET: pulse in cycles 1..PW_CYC, recovery in cycles PW_CYC+1..PW_CYC+REC_CYC, rsp_valid in cycle PW_CYC+REC_CYC+1.
- Throughput: one command per op duration + 1 cycle; there is no overlap.
- All dut_* outputs are flop outputs (glitch-free). rsp_* are valid only while rsp_valid = 1.

## Structure
- Package dffasr_stim_pkg holds:
  - op_e typedef: LOAD0, LOAD1, RESET, SET.
  - state_e typedef: IDLE, DRIVE, CLK_HI, CLK_LO, PULSE, RECOV, SAMPLE.
  - Cycle constants for the LOAD sequence.
- Sub-module dffasr_stim_timer: loadable down-counter sized for max(PW_CYC, REC_CYC), with a done flag. It is used by PULSE and RECOV.
- Top level contains the FSM, output registers, checker and saturating counter.

## Test plan
- LOAD1 then LOAD0 with a DFFASRX1 DUT:
  - Each rsp_valid arrives 4 cycles after acceptance.
  - Responses are rsp_q = 1 then 0, rsp_pass = 1 for both; err_cnt = 0.
- SET then RESET with PW_CYC = 3, REC_CYC = 2:
  - dut_setb is low exactly 3 cycles; dut_rstb stays 1 throughout.
  - rsp at cycle 6 with q = 1, then q = 0; both pass.
- Fault injection: tie dut_qn to dut_q, then issue LOAD1 → rsp_pass = 0 and err_cnt = 1.
- Saturation: ERR_W = 2 with a stuck-at-0 DUT, 5 LOAD1 ops → err_cnt stays at 3.
- Backpressure:
  - Hold cmd_valid continuously with changing cmd_op: only ops present while cmd_ready = 1 are executed.
  - The dut_rstb/dut_setb never-both-low assertion holds.
- Mid-op reset: drop RSTB during RESET PULSE cycle 2 → dut_rstb = 1 immediately, no rsp_valid, err_cnt = 0, cmd_ready = 1.
